// File: rtl/timer_mmio_periph.sv
// timer_mmio_periph
// Memory-mapped peripheral on the CPU MEM-stage load/store bus. It contains:
//   - a reloadable 32-bit up-counter (TH/TL) with an interrupt request
//   - a free-running 32-bit systick counter
//   - the LED and 7-segment output registers
// Loads are answered combinationally in the same cycle. Stores take effect
// on the clock edge.
//
// Register map (byte offsets from BASE_ADDR; addr[1:0] is ignored):
//   0x00 TH       reload value, copied into TL when TL overflows
//   0x04 TL       counter value
//   0x08 TCON     bit0 EN (count enable), bit1 IE (interrupt enable),
//                 bit2 IS (interrupt status)
//   0x0C LEDS     LED register, LED_W bits wide
//   0x10 DIGI     7-segment register, DIGI_W bits wide
//   0x14 SYSTICK  free-running counter; writable
//   0x18..0x1F    not decoded, so hit is 0
module timer_mmio_periph #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          LED_W     = 8,
   parameter int          DIGI_W    = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              hit,
   output logic              irq,
   output logic [LED_W-1:0]  leds,
   output logic [DIGI_W-1:0] digi
);

   // Word indices of the registers inside the 32-byte decode window.
   localparam int         NUM_REGS    = 6;
   localparam logic [2:0] IDX_TH      = 3'd0;
   localparam logic [2:0] IDX_TL      = 3'd1;
   localparam logic [2:0] IDX_TCON    = 3'd2;
   localparam logic [2:0] IDX_LEDS    = 3'd3;
   localparam logic [2:0] IDX_DIGI    = 3'd4;
   localparam logic [2:0] IDX_SYSTICK = 3'd5;

   // Bit positions inside TCON.
   localparam int TCON_EN = 0;
   localparam int TCON_IE = 1;
   localparam int TCON_IS = 2;

   localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

   // Architectural registers.
   logic [31:0]       th_reg;
   logic [31:0]       tl_reg;
   logic [2:0]        tcon_reg;
   logic [LED_W-1:0]  leds_reg;
   logic [DIGI_W-1:0] digi_reg;
   logic [31:0]       systick_reg;

   // Next-state values.
   logic [31:0]       th_next;
   logic [31:0]       tl_next;
   logic [2:0]        tcon_next;
   logic [LED_W-1:0]  leds_next;
   logic [DIGI_W-1:0] digi_next;
   logic [31:0]       systick_next;

   // Address decode.
   logic                in_window;
   logic [2:0]          reg_index;
   logic [NUM_REGS-1:0] sel;
   logic [NUM_REGS-1:0] wr_sel;

   // Timer control signals.
   logic timer_en;
   logic int_en;
   logic int_status;
   logic tl_at_max;
   logic overflow;
   logic overflow_irq;

   // The byte-lane bits take no part in decoding. This signal only
   // exists to show that they are ignored on purpose.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr[1:0];

   // The window is 32-byte aligned, so one upper-bit compare selects it.
   // The word index then picks the register.
   assign in_window = (addr[31:5] == BASE_ADDR[31:5]);
   assign reg_index = addr[4:2];

   // One-hot select and write strobe for each implemented register.
   // Indices 6 and 7 fall in the window but have no register, so they
   // do not produce a hit.
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sel
         assign sel[gi]    = in_window && (reg_index == 3'(gi));
         assign wr_sel[gi] = MemWrite && sel[gi];
      end
   endgenerate

   assign hit = |sel;

   // Short names for the TCON fields.
   assign timer_en   = tcon_reg[TCON_EN];
   assign int_en     = tcon_reg[TCON_IE];
   assign int_status = tcon_reg[TCON_IS];

   // Overflow is the counting edge on which TL is at all-ones.
   // The interrupt status is set only if IE is already set on that edge.
   assign tl_at_max    = (tl_reg == TL_MAX);
   assign overflow     = timer_en && tl_at_max;
   assign overflow_irq = overflow && int_en;

   // The interrupt request comes straight from the registers, so it
   // drops in the cycle after an acknowledge or a reset.
   assign irq = int_en && int_status;

   assign leds = leds_reg;
   assign digi = digi_reg;

   // Load data mux. Registers narrower than 32 bits are zero-extended.
   // A simultaneous store has not taken effect yet, so a load always
   // sees the value from before the write.
   always_comb begin
      rdata = 32'd0;
      if (MemRead && hit) begin
         case (reg_index)
            IDX_TH:      rdata = th_reg;
            IDX_TL:      rdata = tl_reg;
            IDX_TCON:    rdata = {29'd0, tcon_reg};
            IDX_LEDS:    rdata = {{(32-LED_W){1'b0}}, leds_reg};
            IDX_DIGI:    rdata = {{(32-DIGI_W){1'b0}}, digi_reg};
            IDX_SYSTICK: rdata = systick_reg;
            default:     rdata = 32'd0;
         endcase
      end
   end

   // Counter next state.
   // A store to TL takes priority over both increment and reload.
   // A reload uses the TH value from before the edge, even if TH is
   // written on the same edge.
   always_comb begin
      tl_next = tl_reg;
      if (wr_sel[IDX_TL]) begin
         tl_next = wdata;
      end else if (timer_en) begin
         if (tl_at_max) begin
            tl_next = th_reg;
         end else begin
            tl_next = tl_reg + 32'd1;
         end
      end
   end

   // Reload register next state.
   always_comb begin
      th_next = th_reg;
      if (wr_sel[IDX_TH]) begin
         th_next = wdata;
      end
   end

   // TCON next state.
   // A store sets EN and IE from wdata. IS is ORed with a same-edge
   // overflow, so an interrupt cannot be lost when it races an ack.
   // IS clears only when a store writes 0 to it and no overflow sets it.
   // If a store to TL coincides with an overflow, the store still owns TL,
   // but the overflow is still reported in IS.
   always_comb begin
      tcon_next = tcon_reg;
      if (wr_sel[IDX_TCON]) begin
         tcon_next[TCON_EN] = wdata[TCON_EN];
         tcon_next[TCON_IE] = wdata[TCON_IE];
         tcon_next[TCON_IS] = wdata[TCON_IS] || overflow_irq;
      end else begin
         tcon_next[TCON_IS] = int_status || overflow_irq;
      end
   end

   // Output registers and systick next state.
   // SYSTICK counts every cycle and wraps. A store to SYSTICK wins over
   // the increment.
   always_comb begin
      leds_next    = leds_reg;
      digi_next    = digi_reg;
      systick_next = systick_reg + 32'd1;
      if (wr_sel[IDX_LEDS]) begin
         leds_next = wdata[LED_W-1:0];
      end
      if (wr_sel[IDX_DIGI]) begin
         digi_next = wdata[DIGI_W-1:0];
      end
      if (wr_sel[IDX_SYSTICK]) begin
         systick_next = wdata;
      end
   end

   // Register update with synchronous reset.
   // A reset during counting clears every register on that edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         th_reg      <= 32'd0;
         tl_reg      <= 32'd0;
         tcon_reg    <= 3'd0;
         leds_reg    <= '0;
         digi_reg    <= '0;
         systick_reg <= 32'd0;
      end else begin
         th_reg      <= th_next;
         tl_reg      <= tl_next;
         tcon_reg    <= tcon_next;
         leds_reg    <= leds_next;
         digi_reg    <= digi_next;
         systick_reg <= systick_next;
      end
   end

endmodule

// File: tb/tb_timer_mmio_periph.sv
// Testbench for timer_mmio_periph.
// The directed tasks cover reset, overflow and reload, the interrupt
// ack race, store collisions, the output registers and systick wrap.
// A random phase then compares the DUT with a behavioural model
// every cycle.
module tb_timer_mmio_periph;

   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        hit;
   logic        irq;
   logic [7:0]  leds;
   logic [11:0] digi;

   int vectors     = 0;
   int miscompares = 0;

   // Behavioural model of the register file.
   logic [31:0] m_th, m_tl, m_sys;
   logic        m_en, m_ie, m_is;
   logic [7:0]  m_leds;
   logic [11:0] m_digi;

   timer_mmio_periph #(
      .BASE_ADDR (BASE),
      .LED_W     (8),
      .DIGI_W    (12)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .hit      (hit),
      .irq      (irq),
      .leds     (leds),
      .digi     (digi)
   );

   always #5 clk = ~clk;

   // An address hits when it is one of the 24 bytes starting at BASE.
   function automatic logic m_hit(input logic [31:0] a);
      return (a >= BASE) && ((a - BASE) < 32'd24);
   endfunction

   // Data a load from this address would return.
   function automatic logic [31:0] m_read(input logic rd, input logic [31:0] a);
      int idx;
      if (!rd || !m_hit(a)) return 32'd0;
      idx = int'((a - BASE) / 4);
      case (idx)
         0: return m_th;
         1: return m_tl;
         2: return {29'd0, m_is, m_ie, m_en};
         3: return {24'd0, m_leds};
         4: return {20'd0, m_digi};
         5: return m_sys;
         default: return 32'd0;
      endcase
   endfunction

   // Apply one clock edge to the model, using the current bus inputs.
   task automatic model_step();
      logic        ovf;
      logic [31:0] n_th, n_tl, n_sys;
      logic        n_en, n_ie, n_is;
      logic [7:0]  n_leds;
      logic [11:0] n_digi;
      int          idx;
      if (reset) begin
         m_th = 0; m_tl = 0; m_sys = 0; m_en = 0; m_ie = 0; m_is = 0;
         m_leds = 0; m_digi = 0;
      end else begin
         ovf    = m_en && (m_tl == 32'hFFFF_FFFF);
         n_th   = m_th;
         n_tl   = !m_en ? m_tl : (ovf ? m_th : m_tl + 32'd1);
         n_en   = m_en;
         n_ie   = m_ie;
         n_is   = m_is || (ovf && m_ie);
         n_leds = m_leds;
         n_digi = m_digi;
         n_sys  = m_sys + 32'd1;
         if (MemWrite && m_hit(addr)) begin
            idx = int'((addr - BASE) / 4);
            case (idx)
               0: n_th = wdata;
               1: n_tl = wdata;
               2: begin
                  n_en = wdata[0];
                  n_ie = wdata[1];
                  n_is = wdata[2] || (ovf && m_ie);
               end
               3: n_leds = wdata[7:0];
               4: n_digi = wdata[11:0];
               5: n_sys = wdata;
               default: ;
            endcase
         end
         m_th = n_th; m_tl = n_tl; m_sys = n_sys;
         m_en = n_en; m_ie = n_ie; m_is = n_is;
         m_leds = n_leds; m_digi = n_digi;
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      MemRead  = rd;
      MemWrite = wr;
      addr     = a;
      wdata    = d;
   endtask

   // Advance one clock edge and keep the model in step.
   // Returns at the following falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 32'd0);
      tick();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, BASE + 32'(i * 4), 32'd0);
         #1;
         vectors++;
         if (rdata !== 32'd0 || hit !== 1'b1 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_read off=%0h got rdata=%h hit=%b irq=%b exp rdata=0 hit=1 irq=0",
                     i * 4, rdata, hit, irq);
         end
         tick();
      end
      drive(1'b1, 1'b0, BASE + 32'h18, 32'd0);
      #1;
      vectors++;
      if (rdata !== 32'd0 || hit !== 1'b0 || leds !== 8'd0 || digi !== 12'd0) begin
         miscompares++;
         $display("FAIL reset_miss got rdata=%h hit=%b leds=%h digi=%h exp all 0", rdata, hit, leds, digi);
      end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_timer_overflow();
      drive(1'b0, 1'b1, BASE + 32'h0, 32'hFFFF_FFF0); tick();
      drive(1'b0, 1'b1, BASE + 32'h4, 32'hFFFF_FFFE); tick();
      drive(1'b0, 1'b1, BASE + 32'h8, 32'd3);         tick();
      drive(1'b0, 1'b0, 32'd0, 32'd0);                tick(); tick();
      drive(1'b1, 1'b0, BASE + 32'h4, 32'd0);
      #1;
      vectors++;
      if (rdata !== 32'hFFFF_FFF0 || irq !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_reload got tl=%h irq=%b exp tl=fffffff0 irq=1", rdata, irq);
      end
      drive(1'b1, 1'b0, BASE + 32'h8, 32'd0);
      #1;
      vectors++;
      if (rdata !== 32'd7) begin
         miscompares++;
         $display("FAIL ovf_tcon got %h exp 7", rdata);
      end
      tick();
      drive(1'b1, 1'b0, BASE + 32'h4, 32'd0);
      #1;
      vectors++;
      if (rdata !== 32'hFFFF_FFF1) begin
         miscompares++;
         $display("FAIL ovf_next got %h exp fffffff1", rdata);
      end
   endtask

   task automatic test_irq_ack();
      drive(1'b0, 1'b1, BASE + 32'h8, 32'd3);
      tick();
      drive(1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++;
         $display("FAIL irq_ack got irq=%b exp 0", irq);
      end
      // An ack store that lands on the overflow edge must not lose the interrupt.
      drive(1'b0, 1'b1, BASE + 32'h4, 32'hFFFF_FFFE); tick();
      drive(1'b0, 1'b0, 32'd0, 32'd0);                tick();
      drive(1'b0, 1'b1, BASE + 32'h8, 32'd3);         tick();
      drive(1'b1, 1'b0, BASE + 32'h8, 32'd0);
      #1;
      vectors++;
      if (rdata !== 32'd7 || irq !== 1'b1) begin
         miscompares++;
         $display("FAIL ack_race_ie got tcon=%h irq=%b exp tcon=7 irq=1", rdata, irq);
      end
      // A TCON=1 store on the overflow edge keeps IS but turns IE off.
      drive(1'b0, 1'b1, BASE + 32'h8, 32'd3);         tick();
      drive(1'b0, 1'b1, BASE + 32'h4, 32'hFFFF_FFFF); tick();
      drive(1'b0, 1'b1, BASE + 32'h8, 32'd1);         tick();
      drive(1'b1, 1'b0, BASE + 32'h8, 32'd0);
      #1;
      vectors++;
      if (rdata !== 32'd5 || irq !== 1'b0) begin
         miscompares++;
         $display("FAIL ack_race_noie got tcon=%h irq=%b exp tcon=5 irq=0", rdata, irq);
      end
   endtask

   task automatic test_store_collision();
      // A store to TL on the overflow edge wins over the reload.
      drive(1'b0, 1'b1, BASE + 32'h4, 32'hFFFF_FFFE); tick();
      drive(1'b0, 1'b0, 32'd0, 32'd0);                tick();
      drive(1'b0, 1'b1, BASE + 32'h4, 32'h0000_1234); tick();
      drive(1'b1, 1'b0, BASE + 32'h4, 32'd0);
      #1;
      vectors++;
      if (rdata !== 32'h0000_1234) begin
         miscompares++;
         $display("FAIL tl_store_wins got %h exp 00001234", rdata);
      end
      // A store to TH on the reload edge: TL takes the old TH.
      drive(1'b0, 1'b1, BASE + 32'h4, 32'hFFFF_FFFF); tick();
      drive(1'b0, 1'b1, BASE + 32'h0, 32'h0000_ABCD); tick();
      drive(1'b1, 1'b0, BASE + 32'h4, 32'd0);
      #1;
      vectors++;
      if (rdata !== 32'hFFFF_FFF0) begin
         miscompares++;
         $display("FAIL th_reload_old got tl=%h exp fffffff0", rdata);
      end
      drive(1'b1, 1'b0, BASE + 32'h0, 32'd0);
      #1;
      vectors++;
      if (rdata !== 32'h0000_ABCD) begin
         miscompares++;
         $display("FAIL th_new got %h exp 0000abcd", rdata);
      end
      // Stop the timer. EN is still 1 on this edge, so TL steps once more.
      drive(1'b0, 1'b1, BASE + 32'h8, 32'd0); tick();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b0, BASE + 32'h4, 32'd0);
         #1;
         vectors++;
         if (rdata !== 32'hFFFF_FFF1) begin
            miscompares++;
            $display("FAIL tl_frozen cyc=%0d got %h exp fffffff1", i, rdata);
         end
         tick();
      end
   endtask

   task automatic test_leds_digi();
      drive(1'b0, 1'b1, BASE + 32'h0C, 32'h0000_01A5); tick();
      drive(1'b0, 1'b1, BASE + 32'h10, 32'h0000_FABC); tick();
      drive(1'b1, 1'b0, BASE + 32'h0C, 32'd0);
      #1;
      vectors++;
      if (leds !== 8'hA5 || digi !== 12'hABC || rdata !== 32'h0000_00A5) begin
         miscompares++;
         $display("FAIL leds_digi got leds=%h digi=%h rd=%h exp a5 abc 000000a5", leds, digi, rdata);
      end
      drive(1'b1, 1'b0, BASE + 32'h10, 32'd0);
      #1;
      vectors++;
      if (rdata !== 32'h0000_0ABC) begin
         miscompares++;
         $display("FAIL digi_read got %h exp 00000abc", rdata);
      end
      // A load together with a store returns the value from before the store.
      drive(1'b1, 1'b1, BASE + 32'h0C, 32'h0000_005A);
      #1;
      vectors++;
      if (rdata !== 32'h0000_00A5) begin
         miscompares++;
         $display("FAIL rw_same got %h exp 000000a5", rdata);
      end
      tick();
      drive(1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      vectors++;
      if (leds !== 8'h5A) begin
         miscompares++;
         $display("FAIL rw_write got leds=%h exp 5a", leds);
      end
   endtask

   task automatic test_systick_reset();
      drive(1'b0, 1'b1, BASE + 32'h14, 32'hFFFF_FFFF); tick();
      drive(1'b1, 1'b0, BASE + 32'h14, 32'd0);
      #1;
      vectors++;
      if (rdata !== 32'hFFFF_FFFF) begin
         miscompares++;
         $display("FAIL systick_wr got %h exp ffffffff", rdata);
      end
      tick();
      #1;
      vectors++;
      if (rdata !== 32'd0) begin
         miscompares++;
         $display("FAIL systick_wrap got %h exp 0", rdata);
      end
      // Set EN, IE and IS, then apply reset while the timer is counting.
      drive(1'b0, 1'b1, BASE + 32'h8, 32'd7); tick();
      reset = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_irq got %b exp 1", irq);
      end
      tick();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, BASE + 32'(i * 4), 32'd0);
         #1;
         vectors++;
         if (rdata !== 32'd0 || irq !== 1'b0 || leds !== 8'd0 || digi !== 12'd0) begin
            miscompares++;
            $display("FAIL mid_reset off=%0h got rd=%h irq=%b leds=%h digi=%h exp all 0",
                     i * 4, rdata, irq, leds, digi);
         end
         tick();
      end
      reset = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] a, d, exp_rd;
      int          kind;
      for (int n = 0; n < 600; n++) begin
         kind = int'($urandom_range(0, 9));
         if (kind < 7)
            a = BASE + $urandom_range(0, 31);
         else if (kind == 7)
            a = BASE - 32'($urandom_range(1, 8));
         else
            a = $urandom;
         if ($urandom_range(0, 2) == 0)
            d = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
         else
            d = $urandom;
         reset = ($urandom_range(0, 149) == 0);
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
         #1;
         exp_rd = m_read(MemRead, addr);
         vectors++;
         if (rdata !== exp_rd || hit !== m_hit(addr) || irq !== (m_ie && m_is) ||
             leds !== m_leds || digi !== m_digi) begin
            miscompares++;
            $display("FAIL random n=%0d addr=%h got rd=%h hit=%b irq=%b leds=%h digi=%h exp rd=%h hit=%b irq=%b leds=%h digi=%h",
                     n, addr, rdata, hit, irq, leds, digi,
                     exp_rd, m_hit(addr), m_ie && m_is, m_leds, m_digi);
         end
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 32'd0);
      m_th = 0; m_tl = 0; m_sys = 0; m_en = 0; m_ie = 0; m_is = 0;
      m_leds = 0; m_digi = 0;
      @(negedge clk);
      test_reset();
      test_timer_overflow();
      test_irq_ack();
      test_store_collision();
      test_leds_digi();
      test_systick_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
